// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit add/subtract split into STAGES carry-chained
// slices, one slice per clock, behind a valid/ready handshake with full
// backpressure. The result and flags come straight from the last stage's
// registers.
//
// Each stage register holds a single word, acc, for the operation it carries.
// The slices already processed hold sum bits and the slices not yet processed
// still hold operand A. Alongside it travel the effective B operand, the
// carry out of the slice just added, and a valid bit.

module pipelined_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  if (STAGES < 1) begin : g_bad_stages
    $error("pipelined_addsub: STAGES must be at least 1");
  end
  if ((STAGES >= 1) && ((WIDTH % STAGES) != 0)) begin : g_bad_width
    $error("pipelined_addsub: WIDTH must be a multiple of STAGES");
  end

  // Stage registers, one entry per stage
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] cy_q;
  logic [WIDTH-1:0]  acc_q  [STAGES];
  logic [WIDTH-1:0]  beff_q [STAGES];
  logic              ovf_q;

  // Values presented to each stage, and what each stage will capture
  logic [STAGES-1:0] vld_d;
  logic [STAGES-1:0] cy_in;
  logic [STAGES-1:0] cy_d;
  logic [WIDTH-1:0]  acc_in [STAGES];
  logic [WIDTH-1:0]  acc_d  [STAGES];
  logic [WIDTH-1:0]  beff_d [STAGES];
  logic              ovf_d;
  logic              advance;

  // The whole pipe moves as a unit. It freezes only when a result is
  // waiting and the consumer is not taking it.
  assign advance   = !vld_q[LAST] || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_q[LAST];
  assign sum       = acc_q[LAST];
  assign cout      = cy_q[LAST];
  assign ovf       = ovf_q;

  // Stage input mux. Stage 0 takes the new operands. Subtraction becomes
  // addition of ~b with carry-in ~cin. Later stages take the registers of
  // the stage before.
  always_comb begin
    vld_d  = '0;
    cy_in  = '0;
    acc_in = '{default: '0};
    beff_d = '{default: '0};

    vld_d[0]  = in_valid;
    acc_in[0] = a;
    beff_d[0] = sub ? ~b : b;
    cy_in[0]  = sub ^ cin;

    for (int k = 1; k < STAGES; k++) begin
      vld_d[k]  = vld_q[k-1];
      acc_in[k] = acc_q[k-1];
      beff_d[k] = beff_q[k-1];
      cy_in[k]  = cy_q[k-1];
    end
  end

  // Each stage adds its own slice, k. The sum replaces the A bits of that
  // slice in acc. Overflow is judged in the last stage. That stage still sees
  // the original A sign bit on its input, before the final slice overwrites it.
  always_comb begin
    acc_d = '{default: '0};
    cy_d  = '0;
    ovf_d = 1'b0;

    for (int k = 0; k < STAGES; k++) begin
      acc_d[k] = acc_in[k];
      {cy_d[k], acc_d[k][k*SW +: SW]} = {1'b0, acc_in[k][k*SW +: SW]}
                                      + {1'b0, beff_d[k][k*SW +: SW]}
                                      + {{SW{1'b0}}, cy_in[k]};
    end

    ovf_d = (acc_in[LAST][WIDTH-1] == beff_d[LAST][WIDTH-1]) &&
            (acc_d[LAST][WIDTH-1]  != acc_in[LAST][WIDTH-1]);
  end

  // Pipeline registers. Reset wins over any handshake. Valid bits always
  // shift on advance. Data is captured only for real ops, so outputs keep
  // their last result while bubbles pass through.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      cy_q  <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        acc_q[k]  <= '0;
        beff_q[k] <= '0;
      end
    end else if (advance) begin
      vld_q <= vld_d;
      for (int k = 0; k < STAGES; k++) begin
        if (vld_d[k]) begin
          acc_q[k]  <= acc_d[k];
          beff_q[k] <= beff_d[k];
          cy_q[k]   <= cy_d[k];
        end
      end
      if (vld_d[LAST]) begin
        ovf_q <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub. Four instances run side by side with
// STAGES = 1, 2, 4 and 16 and share the same stimulus. Each op is pushed
// into the queue of every instance that accepts it. A monitor pops from
// those queues and compares whenever an instance hands out a result.
`timescale 1ns/1ps

module tb_pipelined_addsub;

  localparam int W  = 16;
  localparam int NI = 4;

  function automatic int st_of(input int i);
    case (i)
      0:       return 1;
      1:       return 2;
      2:       return 4;
      default: return 16;
    endcase
  endfunction

  typedef struct packed {
    logic [17:0] res;    // {ovf, cout, sum}
    logic [31:0] stamp;  // cycle the op was accepted
    logic        exact;  // out_ready held high since acceptance
  } sb_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [17:0] exp;
  } vec_t;

  logic clk, rst, in_valid, out_ready, cin, sub;
  logic [W-1:0] a, b;
  logic         in_ready_w  [NI];
  logic         out_valid_w [NI];
  logic [W-1:0] sum_w       [NI];
  logic         cout_w      [NI];
  logic         ovf_w       [NI];

  sb_t sb_q [NI][$];
  int  cyc;
  int  checks;
  int  errors;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    pipelined_addsub #(.WIDTH(W), .STAGES(st_of(g))) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready_w[g]),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid_w[g]),
      .out_ready (out_ready),
      .sum       (sum_w[g]),
      .cout      (cout_w[g]),
      .ovf       (ovf_w[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Reference: {ovf, cout, sum}
  function automatic logic [17:0] model(input logic [15:0] ia, input logic [15:0] ib,
                                        input logic ic, input logic is);
    logic [15:0] be;
    logic [16:0] r;
    logic        ov;
    be = is ? ~ib : ib;
    r  = {1'b0, ia} + {1'b0, be} + {16'd0, (is ? ~ic : ic)};
    ov = (ia[15] == be[15]) && (r[15] != ia[15]);
    return {ov, r[16], r[15:0]};
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'hFFFF;
      1:       return 16'h8000;
      2:       return 16'h7FFF;
      3:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h", nm, i, act, exp);
    end
  endtask

  // Drive one cycle of stimulus just after the rising edge. At the
  // following falling edge, record the op in every instance that accepts it.
  task automatic issue(input logic v, input logic [15:0] ia, input logic [15:0] ib,
                       input logic ic, input logic is, input logic [17:0] ex,
                       input logic ordy, input logic exact_f);
    sb_t e;
    @(posedge clk);
    #1;
    in_valid  = v;
    a         = ia;
    b         = ib;
    cin       = ic;
    sub       = is;
    out_ready = ordy;
    @(negedge clk);
    if (v && !rst) begin
      for (int i = 0; i < NI; i++) begin
        if (in_ready_w[i]) begin
          e.res   = ex;
          e.stamp = 32'(cyc);
          e.exact = exact_f;
          sb_q[i].push_back(e);
        end
      end
    end
  endtask

  task automatic bubbles(input int n);
    for (int k = 0; k < n; k++) issue(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 18'h0, 1'b1, 1'b1);
  endtask

  // Monitor: pops and compares on every output transfer, checks latency, and
  // checks that stalled outputs hold steady.
  initial begin
    logic        hold_v   [NI];
    logic [18:0] hold_val [NI];
    sb_t         e;
    int          lat;
    for (int i = 0; i < NI; i++) begin
      hold_v[i]   = 1'b0;
      hold_val[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (rst) begin
          hold_v[i] = 1'b0;
        end else begin
          if (hold_v[i]) begin
            checks++;
            if ({out_valid_w[i], ovf_w[i], cout_w[i], sum_w[i]} !== hold_val[i]) begin
              errors++;
              $display("FAIL stall_hold inst%0d: got %0h expected %0h", i,
                       {out_valid_w[i], ovf_w[i], cout_w[i], sum_w[i]}, hold_val[i]);
            end
          end
          hold_v[i] = 1'b0;
          if (out_valid_w[i] && out_ready) begin
            checks++;
            if (sb_q[i].size() == 0) begin
              errors++;
              $display("FAIL unexpected_result inst%0d: got sum=%0h with no op outstanding", i, sum_w[i]);
            end else begin
              e = sb_q[i].pop_front();
              if ({ovf_w[i], cout_w[i], sum_w[i]} !== e.res) begin
                errors++;
                $display("FAIL result inst%0d: got {ovf,cout,sum}=%0h expected %0h", i,
                         {ovf_w[i], cout_w[i], sum_w[i]}, e.res);
              end
              lat = cyc - int'(e.stamp);
              checks++;
              if (e.exact ? (lat != st_of(i)) : (lat < st_of(i))) begin
                errors++;
                $display("FAIL latency inst%0d: got %0d expected %0d", i, lat, st_of(i));
              end
            end
          end else if (out_valid_w[i]) begin
            hold_v[i]   = 1'b1;
            hold_val[i] = {out_valid_w[i], ovf_w[i], cout_w[i], sum_w[i]};
          end
        end
      end
    end
  end

  initial begin
    vec_t        dir_v [9];
    logic [15:0] ra, rb;
    logic        rc, rs;
    logic [18:0] cap;

    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    dir_v[0] = {16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
    dir_v[1] = {16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b1, 16'h7FFF};
    dir_v[2] = {16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF};
    dir_v[3] = {16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 16'h8000};
    dir_v[4] = {16'h1234, 16'h1111, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0122};
    dir_v[5] = {16'h00FF, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0101};
    dir_v[6] = {16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF};
    dir_v[7] = {16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFF};
    dir_v[8] = {16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("reset_out_valid", i, 32'(out_valid_w[i]), 32'd0);
      chk("reset_sum", i, 32'(sum_w[i]), 32'd0);
      chk("reset_cout_ovf", i, 32'({cout_w[i], ovf_w[i]}), 32'd0);
    end
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) chk("in_ready_after_reset", i, 32'(in_ready_w[i]), 32'd1);

    // Directed vectors, back to back, out_ready held high
    for (int k = 0; k < 9; k++)
      issue(1'b1, dir_v[k].a, dir_v[k].b, dir_v[k].cin, dir_v[k].sub, dir_v[k].exp, 1'b1, 1'b1);
    bubbles(20);

    // Eight consecutive ops a=i, b=10*i; results at cycles 4..11, none at 12
    for (int k = 0; k < 8; k++)
      issue(1'b1, 16'(k), 16'(10 * k), 1'b0, 1'b0, {2'b00, 16'(11 * k)}, 1'b1, 1'b1);
    bubbles(4);
    chk("burst_valid_cycle11", 2, 32'(out_valid_w[2]), 32'd1);
    bubbles(1);
    chk("burst_valid_cycle12", 2, 32'(out_valid_w[2]), 32'd0);
    bubbles(16);

    // Fill the pipe, then stall the consumer for three cycles
    for (int k = 0; k < 6; k++) begin
      ra = 16'h1111 * 16'(k + 1);
      rb = 16'h0F0F + 16'(k);
      issue(1'b1, ra, rb, k[0], k[1], model(ra, rb, k[0], k[1]), 1'b1, 1'b0);
    end
    for (int s = 0; s < 3; s++) begin
      ra = 16'hA000 + 16'(s);
      rb = 16'h6000;
      issue(1'b1, ra, rb, 1'b0, 1'b0, model(ra, rb, 1'b0, 1'b0), 1'b0, 1'b0);
      chk("stall_in_ready", 2, 32'(in_ready_w[2]), 32'd0);
      if (s == 0) cap = {out_valid_w[2], ovf_w[2], cout_w[2], sum_w[2]};
      else chk("stall_outputs_stable", 2, 32'({out_valid_w[2], ovf_w[2], cout_w[2], sum_w[2]}), 32'(cap));
    end
    chk("stall_out_valid", 2, 32'(out_valid_w[2]), 32'd1);
    bubbles(24);

    // Reset with three ops in flight; inputs during reset must be ignored
    for (int k = 0; k < 3; k++)
      issue(1'b1, 16'h4000 + 16'(k), 16'h0003, 1'b1, 1'b0, model(16'h4000 + 16'(k), 16'h0003, 1'b1, 1'b0), 1'b1, 1'b1);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 16'hBEEF;
    b        = 16'h1234;
    for (int i = 0; i < NI; i++) sb_q[i].delete();
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("midreset_out_valid", i, 32'(out_valid_w[i]), 32'd0);
      chk("midreset_sum", i, 32'(sum_w[i]), 32'd0);
      chk("midreset_cout_ovf", i, 32'({cout_w[i], ovf_w[i]}), 32'd0);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) chk("in_ready_after_midreset", i, 32'(in_ready_w[i]), 32'd1);
    bubbles(20);

    // Random traffic with random backpressure
    for (int k = 0; k < 300; k++) begin
      ra = pick();
      rb = pick();
      rc = 1'($urandom);
      rs = 1'($urandom);
      issue(($urandom_range(0, 3) != 0), ra, rb, rc, rs, model(ra, rb, rc, rs),
            ($urandom_range(0, 3) != 0), 1'b0);
    end
    bubbles(20);

    // Random traffic with out_ready held high: latency must be exact
    for (int k = 0; k < 100; k++) begin
      ra = pick();
      rb = pick();
      rc = 1'($urandom);
      rs = 1'($urandom);
      issue(($urandom_range(0, 3) != 0), ra, rb, rc, rs, model(ra, rb, rc, rs), 1'b1, 1'b1);
    end
    bubbles(20);

    for (int i = 0; i < NI; i++) chk("scoreboard_drained", i, 32'(sb_q[i].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
